fetch_sequencer: RTL and testbench

- Instruction fetch controller that drives the 8-bit instruction register's load strobe and data input.
- Holds the program counter and reads one instruction byte from program memory over a req/ack handshake.
- Presents the byte to the instruction register with a one-cycle load pulse.
- Sits between the control unit (fetch/jump commands) and program memory.

---
 rtl/fetch_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch controller; owns the PC, reads one byte per fetch over req/ack and pulses ir_load.
// Ports: clk/rst (sync, active-high); fetch, jump, jump_addr from the control unit;
// mem_req/mem_addr/mem_rdata/mem_ack to program memory; ir_load/ir_data to the instruction register;
// pc and busy status. Optional prefetch buffer enabled by defining FETCH_PREFETCH_EN.
module fetch_sequencer #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              ir_load,
  output logic [7:0]        ir_data,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, REQ, LOAD, PREQ} state_t;
  state_t r_state, w_state;
  logic r_req, w_req, r_load, w_load, r_busy, w_busy, r_jp, w_jp;
  logic [ADDR_W-1:0] r_addr, w_addr, r_pc, w_pc, r_tgt, w_tgt, w_ea, w_jt;
  logic [7:0] r_ir, w_ir;
`ifdef FETCH_PREFETCH_EN
  logic [7:0] r_pf, w_pf;
  logic r_pfv, w_pfv, r_fp, w_fp;
`endif
  assign mem_req  = r_req;
  assign mem_addr = r_addr;
  assign ir_load  = r_load;
  assign ir_data  = r_ir;
  assign pc       = r_pc;
  assign busy     = r_busy;
  assign w_ea = jump ? jump_addr : r_pc;
  // a jump arriving in the same cycle as the redirect point beats an older pending one
  assign w_jt = jump ? jump_addr : r_tgt;
  always_comb begin
    w_state = r_state;
    w_req   = r_req;
    w_addr  = r_addr;
    w_pc    = r_pc;
    w_ir    = r_ir;
    w_load  = 1'b0;
    w_busy  = r_busy;
    w_jp    = r_jp;
    w_tgt   = r_tgt;
`ifdef FETCH_PREFETCH_EN
    w_pf  = r_pf;
    w_pfv = jump ? 1'b0 : r_pfv;
    w_fp  = r_fp;
`endif
    if (jump && r_state != IDLE) begin
      w_jp  = 1'b1;
      w_tgt = jump_addr;
    end
    case (r_state)
      IDLE: begin
`ifdef FETCH_PREFETCH_EN
        if (fetch && r_pfv && !jump) begin
          w_load  = 1'b1;
          w_ir    = r_pf;
          w_pc    = r_pc + ADDR_W'(1);
          w_pfv   = 1'b0;
          w_busy  = 1'b1;
          w_state = LOAD;
        end else
`endif
        if (fetch) begin
          w_req   = 1'b1;
          w_addr  = w_ea;
          w_pc    = w_ea;
          w_busy  = 1'b1;
          w_state = REQ;
        end else if (jump) w_pc = jump_addr;
      end
      REQ: if (mem_ack) begin
        w_ir    = mem_rdata;
        w_load  = 1'b1;
        w_req   = 1'b0;
        w_pc    = r_addr + ADDR_W'(1);
        w_state = LOAD;
      end
      LOAD: begin
        w_busy  = 1'b0;
        w_jp    = 1'b0;
        w_state = IDLE;
        w_pc    = (jump || r_jp) ? w_jt : r_pc;
`ifdef FETCH_PREFETCH_EN
        if (!(jump || r_jp)) begin
          w_req   = 1'b1;
          w_addr  = r_pc;
          w_state = PREQ;
        end
`endif
      end
`ifdef FETCH_PREFETCH_EN
      PREQ: begin
        if (fetch) begin
          w_fp   = 1'b1;
          w_busy = 1'b1;
        end
        if (mem_ack) begin
          w_req = 1'b0;
          w_fp  = 1'b0;
          if (jump || r_jp) begin
            // redirected while the prefetch was in flight: drop the byte
            w_pc    = w_jt;
            w_jp    = 1'b0;
            w_busy  = 1'b0;
            w_state = IDLE;
          end else if (r_fp || fetch) begin
            w_ir    = mem_rdata;
            w_load  = 1'b1;
            w_pc    = r_addr + ADDR_W'(1);
            w_busy  = 1'b1;
            w_state = LOAD;
          end else begin
            w_pf    = mem_rdata;
            w_pfv   = 1'b1;
            w_state = IDLE;
          end
        end
      end
`endif
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_jp    <= 1'b0;
      r_tgt   <= '0;
`ifdef FETCH_PREFETCH_EN
      r_pf    <= '0;
      r_pfv   <= 1'b0;
      r_fp    <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_req   <= w_req;
      r_addr  <= w_addr;
      r_pc    <= w_pc;
      r_ir    <= w_ir;
      r_load  <= w_load;
      r_busy  <= w_busy;
      r_jp    <= w_jp;
      r_tgt   <= w_tgt;
`ifdef FETCH_PREFETCH_EN
      r_pf    <= w_pf;
      r_pfv   <= w_pfv;
      r_fp    <= w_fp;
`endif
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: self-checking bench for fetch_sequencer against a transaction-level PC/data model.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst, fetch, jump, mem_ack;
  logic [7:0] jump_addr, mem_rdata, mem_addr, ir_data, pc;
  logic mem_req, ir_load, busy;
  int total = 0, bad = 0;
  logic [7:0] m_pc;
  logic [7:0] a, d, p;
  int stab_bad, loads;
  logic busy_mid, busy_end, req_end;

  fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .fetch(fetch), .jump(jump), .jump_addr(jump_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ir_load(ir_load), .ir_data(ir_data), .pc(pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic run_txn(input logic jn, input logic [7:0] ja, input int dly, input logic [7:0] dat,
                         input logic mj, input logic [7:0] ja2, input logic fd,
                         output logic [7:0] oa, output int ostab, output int oloads, output logic [7:0] od,
                         output logic obm, output logic obe, output logic [7:0] op, output logic ore);
    @(negedge clk);
    fetch = 1'b1; jump = jn; jump_addr = ja;
    @(negedge clk);
    fetch = fd; jump = 1'b0;
    oa = mem_addr;
    ostab = (mem_req !== 1'b1) ? 1 : 0;
    oloads = int'(ir_load);
    obm = busy;
    for (int i = 0; i < dly; i++) begin
      jump = mj && (i == 0); jump_addr = ja2; mem_rdata = 8'($urandom);
      @(negedge clk);
      jump = 1'b0;
      if (mem_req !== 1'b1 || mem_addr !== oa) ostab++;
      oloads += int'(ir_load);
    end
    jump = mj && (dly == 0); jump_addr = ja2;
    mem_ack = 1'b1; mem_rdata = dat;
    @(negedge clk);
    mem_ack = 1'b0; jump = 1'b0; fetch = 1'b0; mem_rdata = 8'($urandom);
    od = ir_data;
    oloads += int'(ir_load);
    @(negedge clk);
    oloads += int'(ir_load);
    obe = busy;
    op = pc;
    @(negedge clk);
    oloads += int'(ir_load);
    ore = mem_req;
  endtask

  task automatic test_reset;
    rst = 1'b1; fetch = 1'b0; jump = 1'b0; jump_addr = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", mem_addr); end
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", pc); end
    total++; if (ir_load !== 1'b0 || ir_data !== 8'h00) begin bad++; $display("FAIL reset_ir got=%b/%h exp=0/00", ir_load, ir_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    m_pc = 8'h00;
  endtask

  task automatic test_basic;
    run_txn(1'b0, 8'h00, 0, 8'hA5, 1'b0, 8'h00, 1'b0, a, stab_bad, loads, d, busy_mid, busy_end, p, req_end);
    total++; if (a !== 8'h00) begin bad++; $display("FAIL basic_addr got=%h exp=00", a); end
    total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL basic_busy_mid got=%b exp=1", busy_mid); end
    total++; if (loads != 1) begin bad++; $display("FAIL basic_loads got=%0d exp=1", loads); end
    total++; if (d !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", d); end
    total++; if (p !== 8'h01) begin bad++; $display("FAIL basic_pc got=%h exp=01", p); end
    total++; if (busy_end !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy_end); end
    m_pc = 8'h01;
  endtask

  task automatic test_delayed_ack;
    run_txn(1'b0, 8'h00, 5, 8'h3C, 1'b0, 8'h00, 1'b0, a, stab_bad, loads, d, busy_mid, busy_end, p, req_end);
    total++; if (a !== 8'h01) begin bad++; $display("FAIL delay_addr got=%h exp=01", a); end
    total++; if (stab_bad != 0) begin bad++; $display("FAIL delay_stable got=%0d exp=0", stab_bad); end
    total++; if (loads != 1) begin bad++; $display("FAIL delay_loads got=%0d exp=1", loads); end
    total++; if (d !== 8'h3C) begin bad++; $display("FAIL delay_data got=%h exp=3c", d); end
    total++; if (p !== 8'h02) begin bad++; $display("FAIL delay_pc got=%h exp=02", p); end
    m_pc = 8'h02;
  endtask

  task automatic test_jumps;
    run_txn(1'b1, 8'h40, 1, 8'h11, 1'b0, 8'h00, 1'b0, a, stab_bad, loads, d, busy_mid, busy_end, p, req_end);
    total++; if (a !== 8'h40) begin bad++; $display("FAIL jump_same_addr got=%h exp=40", a); end
    total++; if (p !== 8'h41) begin bad++; $display("FAIL jump_same_pc got=%h exp=41", p); end
    run_txn(1'b0, 8'h00, 2, 8'h22, 1'b1, 8'h10, 1'b0, a, stab_bad, loads, d, busy_mid, busy_end, p, req_end);
    total++; if (a !== 8'h41) begin bad++; $display("FAIL jump_req_addr got=%h exp=41", a); end
    total++; if (d !== 8'h22) begin bad++; $display("FAIL jump_req_data got=%h exp=22", d); end
    total++; if (p !== 8'h10) begin bad++; $display("FAIL jump_req_pc got=%h exp=10", p); end
    @(negedge clk);
    jump = 1'b1; jump_addr = 8'h77;
    @(negedge clk);
    jump = 1'b0;
    total++; if (pc !== 8'h77 || mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_jump got=%h/%b/%b exp=77/0/0", pc, mem_req, busy); end
    m_pc = 8'h77;
  endtask

  task automatic test_wrap;
    run_txn(1'b1, 8'hFF, 0, 8'h5A, 1'b0, 8'h00, 1'b0, a, stab_bad, loads, d, busy_mid, busy_end, p, req_end);
    total++; if (a !== 8'hFF) begin bad++; $display("FAIL wrap_addr got=%h exp=ff", a); end
    total++; if (p !== 8'h00) begin bad++; $display("FAIL wrap_pc got=%h exp=00", p); end
    m_pc = 8'h00;
  endtask

  task automatic test_fetch_during_req;
    run_txn(1'b0, 8'h00, 3, 8'h99, 1'b0, 8'h00, 1'b1, a, stab_bad, loads, d, busy_mid, busy_end, p, req_end);
    total++; if (loads != 1) begin bad++; $display("FAIL busy_fetch_loads got=%0d exp=1", loads); end
    total++; if (req_end !== 1'b0) begin bad++; $display("FAIL busy_fetch_req got=%b exp=0", req_end); end
    total++; if (p !== 8'h01) begin bad++; $display("FAIL busy_fetch_pc got=%h exp=01", p); end
    m_pc = 8'h01;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    fetch = 1'b1;
    @(negedge clk);
    fetch = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rmid_req_before got=%b exp=1", mem_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hEE;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b exp=0", mem_req); end
    @(negedge clk);
    mem_ack = 1'b0;
    total++; if (ir_load !== 1'b0) begin bad++; $display("FAIL rmid_load got=%b exp=0", ir_load); end
    @(negedge clk);
    total++; if (ir_load !== 1'b0 || ir_data !== 8'h00) begin bad++; $display("FAIL rmid_ir got=%b/%h exp=0/00", ir_load, ir_data); end
    total++; if (pc !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL rmid_pc got=%h/%b exp=00/0", pc, busy); end
    m_pc = 8'h00;
  endtask

  task automatic test_random;
    logic jn, mj, fd;
    logic [7:0] ja, ja2, dat, ea, ep;
    int dly;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ja = 8'($urandom);
        @(negedge clk);
        jump = 1'b1; jump_addr = ja;
        @(negedge clk);
        jump = 1'b0;
        m_pc = ja;
        total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_idle_jump n=%0d got=%h exp=%h", n, pc, m_pc); end
      end
      jn = 1'($urandom_range(0, 1)); mj = 1'($urandom_range(0, 1)); fd = 1'($urandom_range(0, 1));
      ja = 8'($urandom); ja2 = 8'($urandom); dat = 8'($urandom); dly = $urandom_range(0, 4);
      ea = jn ? ja : m_pc;
      ep = mj ? ja2 : 8'(ea + 8'd1);
      run_txn(jn, ja, dly, dat, mj, ja2, fd, a, stab_bad, loads, d, busy_mid, busy_end, p, req_end);
      total++; if (a !== ea) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, a, ea); end
      total++; if (stab_bad != 0 || loads != 1) begin bad++; $display("FAIL rnd_handshake n=%0d got=%0d/%0d exp=0/1", n, stab_bad, loads); end
      total++; if (d !== dat) begin bad++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, d, dat); end
      total++; if (p !== ep || busy_end !== 1'b0) begin bad++; $display("FAIL rnd_pc n=%0d got=%h/%b exp=%h/0", n, p, busy_end, ep); end
      m_pc = ep;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_delayed_ack;
    test_jumps;
    test_wrap;
    test_fetch_during_req;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
